// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// State and owner encodings used by the top level.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch was waiting.
// at_limit tells the arbiter that fetch must win the next slot.
module arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int W = $clog2(STARVE_LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(STARVE_LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != LIM) begin
         cnt <= cnt + W'(1);
      end
   end

   assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer: fetch vs. data arbitration,
// one transaction in flight, registered per-port done pulses.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_err,
   input  logic              halt,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_busy,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata
);

   import mem_arb_pkg::*;

   state_t state;
   state_t state_n;
   owner_t owner;
   logic   wr_q;

   logic f_cand;
   logic at_limit;
   logic grant;
   logic pick_if;
   logic mis;
   logic inc;
   logic clr;
   logic cap;

   assign f_cand = if_req & ~halt;

   arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc),
      .clr      (clr),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      grant   = 1'b0;
      pick_if = 1'b0;
      mis     = 1'b0;
      inc     = 1'b0;
      clr     = 1'b0;
      cap     = 1'b0;
      unique case (state)
         IDLE: begin
            clr = ~f_cand;
            if (!mem_busy && (dm_req || f_cand)) begin
               grant   = 1'b1;
               pick_if = f_cand && (!dm_req || at_limit);
               // misaligned data is answered without a memory cycle
               mis     = !pick_if && dm_addr[0];
               inc     = !pick_if && f_cand;
               clr     = pick_if || !f_cand;
               state_n = mis ? RESP : ISSUE;
            end
         end
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (mem_done) begin
               cap     = 1'b1;
               state_n = RESP;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner     <= OWN_IF;
         wr_q      <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_done   <= 1'b0;
         dm_done   <= 1'b0;
         dm_err    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         mem_en  <= grant & ~mis;
         mem_wr  <= grant & ~mis & ~pick_if & dm_wr;
         if_done <= cap & (owner == OWN_IF);
         dm_done <= (cap & (owner == OWN_DM)) | mis;
         dm_err  <= mis;
         if (grant) begin
            owner <= pick_if ? OWN_IF : OWN_DM;
            wr_q  <= ~pick_if & dm_wr;
         end
         if (grant && !mis) begin
            mem_addr  <= pick_if ? if_addr : dm_addr;
            mem_wdata <= pick_if ? '0 : dm_wdata;
         end
         if (cap && !wr_q) begin
            if (owner == OWN_IF) begin
               if_rdata <= mem_rdata;
            end else begin
               dm_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued expectations from a
// word-level memory model, monitor pops on each done pulse.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, halt, dm_req, dm_wr, mem_busy, mem_done;
   logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic        if_done, dm_done, dm_err, mem_en, mem_wr;
   logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int fixed_lat = 1;

   logic [15:0] resp_mem  [0:65535];
   logic [15:0] model_mem [0:65535];
   logic [15:0] if_q [$];
   logic [16:0] dm_q [$];
   logic [15:0] model_last_dm = '0;

   int en_cnt = 0, en_fetch_cnt = 0, if_cnt = 0, dm_cnt = 0;
   int last_en_cyc = 0, last_dm_cyc = 0;
   logic [15:0] last_en_addr = '0;
   logic last_en_wr = 1'b0;
   logic grant_log [$];
   logic prev_en = 1'b0, prev_halt = 1'b0, prev_done = 1'b0;
   logic run = 1'b0;

   mem_arbiter #(
      .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_done(dm_done),
      .dm_rdata(dm_rdata), .dm_err(dm_err),
      .halt(halt),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_busy(mem_busy),
      .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      fails++;
      $display("FAIL %s actual=timeout required=done", nm);
   endtask

   // data access: expectation follows word-level memory semantics
   task automatic dm_op(input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, output int c0);
      int n;
      if (a[0]) begin
         dm_q.push_back({1'b1, model_last_dm});
      end else if (wr) begin
         model_mem[a] = wd;
         dm_q.push_back({1'b0, model_last_dm});
      end else begin
         model_last_dm = model_mem[a];
         dm_q.push_back({1'b0, model_last_dm});
      end
      dm_wr = wr; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
      c0 = cyc;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!dm_done && n < 400);
      if (!dm_done) timeout("dm_wait");
      @(posedge clk); #1;
      dm_req = 1'b0;
   endtask

   task automatic if_op(input logic [15:0] a);
      int n;
      if_q.push_back(model_mem[a]);
      if_addr = a; if_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!if_done && n < 400);
      if (!if_done) timeout("if_wait");
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   // memory responder
   initial begin
      logic [15:0] r_addr;
      logic r_wr;
      int r_lat;
      mem_done = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_en && rst_n) begin
            r_addr = mem_addr; r_wr = mem_wr;
            r_lat = fixed_lat > 0 ? fixed_lat : $urandom_range(1, 3);
            if (r_wr) resp_mem[r_addr] = mem_wdata;
            repeat (r_lat) @(posedge clk);
            #1;
            mem_done = 1'b1;
            mem_rdata = r_wr ? 16'($urandom) : resp_mem[r_addr];
            @(posedge clk); #1;
            mem_done = 1'b0;
            mem_rdata = 16'($urandom);
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic [15:0] ei;
      logic [16:0] ed;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mem_en) begin
               en_cnt++;
               last_en_cyc = cyc; last_en_addr = mem_addr;
               last_en_wr = mem_wr;
               grant_log.push_back(mem_addr < 16'h0100);
               chk("en_gap", prev_en, 0);
               if (mem_addr >= 16'h0100) chk("en_align", mem_addr[0], 0);
               if (mem_addr < 16'h0100) begin
                  en_fetch_cnt++;
                  chk("halt_gate", prev_halt, 0);
               end
            end
            if (if_done || dm_done) begin
               chk("done_excl", if_done & dm_done, 0);
               chk("done_gap", prev_done, 0);
            end
            if (if_done) begin
               if_cnt++;
               if (if_q.size() == 0) timeout("if_unexpected");
               else begin
                  ei = if_q.pop_front();
                  chk("if_rdata", if_rdata, ei);
               end
            end
            if (dm_done) begin
               dm_cnt++;
               last_dm_cyc = cyc;
               if (dm_q.size() == 0) timeout("dm_unexpected");
               else begin
                  ed = dm_q.pop_front();
                  chk("dm_err", dm_err, ed[16]);
                  chk("dm_rdata", dm_rdata, ed[15:0]);
               end
            end
         end
         prev_en = mem_en; prev_halt = halt;
         prev_done = if_done | dm_done;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int c0, eb, db, fb;
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) begin
         resp_mem[i]  = init_val(16'(i));
         model_mem[i] = init_val(16'(i));
      end
      resp_mem[16'h0010]  = 16'hBEEF;
      model_mem[16'h0010] = 16'hBEEF;
      rst_n = 1'b0; if_req = 0; halt = 0; dm_req = 0; dm_wr = 0;
      mem_busy = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);   chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_done", if_done, 0); chk("rst_dm_done", dm_done, 0);
      chk("rst_dm_err", dm_err, 0);   chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      dm_op(0, 16'h0010, 0, c0);
      chk("load_en_lat", last_en_cyc - c0, 1);
      chk("load_en_addr", last_en_addr, 16'h0010);
      chk("load_en_wr", last_en_wr, 0);
      chk("load_done_lat", last_dm_cyc - c0, 3);

      dm_op(1, 16'h0100, 16'hCAFE, c0);
      chk("store_en_wr", last_en_wr, 1);
      dm_op(0, 16'h0100, 0, c0);

      eb = en_cnt;
      dm_op(1, 16'h0011, 16'h1234, c0);
      chk("mis_done_lat", last_dm_cyc - c0, 1);
      repeat (3) @(negedge clk);
      chk("mis_no_en", en_cnt - eb, 0);
      @(posedge clk); #1;

      mem_busy = 1'b1;
      fork
         dm_op(0, 16'h0102, 0, c0);
         begin repeat (3) @(posedge clk); #1 mem_busy = 1'b0; end
      join
      chk("busy_en_lat", last_en_cyc - c0, 4);

      grant_log.delete();
      fork
         begin for (int k = 0; k < 2; k++) if_op(16'h0040 + 16'(k * 2)); end
         begin
            int cd;
            for (int k = 0; k < 8; k++) dm_op(0, 16'h0104 + 16'(k * 2), 0, cd);
         end
      join
      chk("grant_cnt", grant_log.size() >= 10, 1);
      for (int i = 0; i < 10 && i < grant_log.size(); i++)
         chk($sformatf("grant%0d", i), grant_log[i], (i % 5) == 4);

      halt = 1'b1;
      fb = en_fetch_cnt;
      db = if_cnt;
      fork
         if_op(16'h0060);
         begin
            int ch;
            repeat (3) @(negedge clk);
            dm_op(0, 16'h0106, 0, ch);
            repeat (15) @(negedge clk);
            chk("halt_no_fetch", en_fetch_cnt - fb, 0);
            @(posedge clk); #1 halt = 1'b0;
         end
      join
      chk("halt_fetch_after", if_cnt - db, 1);
      db = if_cnt;
      fork
         if_op(16'h0062);
         begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!mem_en && n < 50);
            @(posedge clk); #1 halt = 1'b1;
         end
      join
      halt = 1'b0;
      chk("halt_inflight", if_cnt - db, 1);

      fixed_lat = 0;
      run = 1'b1;
      fork
         begin
            fork
               begin
                  int cr;
                  logic wr;
                  for (int k = 0; k < 40; k++) begin
                     a = 16'h0100 + 16'($urandom_range(0, 15) * 2);
                     if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
                     wr = 1'($urandom_range(0, 1));
                     dm_op(wr, a, 16'($urandom), cr);
                     repeat ($urandom_range(0, 3)) @(posedge clk);
                  end
               end
               begin
                  for (int k = 0; k < 30; k++) begin
                     if_op(16'h0040 + 16'($urandom_range(0, 95) * 2));
                     repeat ($urandom_range(0, 3)) @(posedge clk);
                  end
               end
            join
            run = 1'b0;
         end
         begin
            while (run) begin
               @(posedge clk); #1;
               if ($urandom_range(0, 7) == 0) halt = ~halt;
               mem_busy = ($urandom_range(0, 3) == 0);
            end
            halt = 1'b0; mem_busy = 1'b0;
         end
      join
      fixed_lat = 4;
      repeat (4) @(posedge clk); #1;

      dm_wr = 0; dm_addr = 16'h0120; dm_req = 1'b1;
      begin
         int n = 0;
         do begin @(negedge clk); n++; end while (!mem_en && n < 50);
         if (!mem_en) timeout("rst_en_wait");
      end
      @(posedge clk); #1;
      rst_n = 1'b0; dm_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_last_dm = '0;
      @(negedge clk);
      chk("rst2_mem_en", mem_en, 0);  chk("rst2_dm_done", dm_done, 0);
      chk("rst2_if_done", if_done, 0); chk("rst2_dm_rdata", dm_rdata, 0);
      chk("rst2_if_rdata", if_rdata, 0); chk("rst2_mem_addr", mem_addr, 0);
      db = if_cnt + dm_cnt;
      repeat (8) @(negedge clk);
      chk("rst2_no_stale_done", if_cnt + dm_cnt - db, 0);
      fixed_lat = 1;
      @(posedge clk); #1;
      dm_op(0, 16'h0120, 0, c0);
      chk("rst2_next_lat", last_dm_cyc - c0, 3);
      repeat (4) @(negedge clk);
      chk("queues_empty", if_q.size() + dm_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
